// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sweep controller: default datapath sizes,
// the controller state encoding and the running-checksum update.
package alu_seq_pkg;

    localparam int DEF_N       = 32;
    localparam int DEF_ADDR_W  = 3;
    localparam int DEF_NUM_OPS = 6;

    // Widest datapath the checksum helper can handle.
    localparam int CHK_MAX_W   = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_HOLD    = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Rotate the low 'width' bits of chk left by one, then XOR in res.
    // Operands are zero-extended to CHK_MAX_W; bits above 'width' come back 0.
    function automatic logic [CHK_MAX_W-1:0] checksum_next(
        input logic [CHK_MAX_W-1:0] chk,
        input logic [CHK_MAX_W-1:0] res,
        input int unsigned          width
    );
        logic [CHK_MAX_W-1:0] mask;
        logic [CHK_MAX_W-1:0] rot;
        mask = (width >= CHK_MAX_W) ? {CHK_MAX_W{1'b1}}
                                    : ((CHK_MAX_W'(1) << width) - CHK_MAX_W'(1));
        rot  = ((chk << 1) | (chk >> (width - 1))) & mask;
        return rot ^ (res & mask);
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// Single-cycle rising-edge detector for a synchronous button input.
// The pulse is combinational from the current input and the registered
// history, so it is visible in the same cycle the input first reads high.
module detector_flanco (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic flanco_o
);

    logic d_prev_q;

    // Remember last cycle's input level.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            d_prev_q <= 1'b0;
        end else begin
            d_prev_q <= d_i;
        end
    end

    assign flanco_o = d_i & ~d_prev_q;

endmodule

// File: rtl/alu_sequencer.sv
// Sweeps the ALU through every (op, a, b) combination, captures each result
// and carry, holds it for display and folds it into a running checksum.
// Sweep order is op outermost, a middle, b innermost.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_OPS = DEF_NUM_OPS,
    parameter int DWELL   = 50_000_000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              step_mode_i,
    input  logic              step_i,
    input  logic              cin_cfg_i,
    input  logic              invert_cfg_i,
    input  logic [N-1:0]      resultado_i,
    input  logic              c_i,
    output logic [ADDR_W-1:0] addra_o,
    output logic [ADDR_W-1:0] addrb_o,
    output logic [2:0]        operacion_o,
    output logic              c_o,
    output logic              invert_o,
    output logic [N-1:0]      resultado_q_o,
    output logic              carry_q_o,
    output logic [N-1:0]      checksum_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              done_o
);

    // Dwell counter runs 0 .. DWELL-1 inside HOLD.
    localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [2:0]      OP_LAST    = 3'(NUM_OPS - 1);

    state_t              state_q;
    state_t              state_d;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   a_q;
    logic [ADDR_W-1:0]   b_q;
    logic                cin_q;
    logic                inv_q;
    logic [N-1:0]        res_q;
    logic                carry_q;
    logic [N-1:0]        chk_q;
    logic [N-1:0]        chk_next;
    logic [CHK_MAX_W-1:0] chk_wide;
    logic [DW_W-1:0]     dwell_q;
    logic                step_edge;
    logic                last_vec;
    logic                start_go;
    logic                dwell_expired;

    detector_flanco u_step_edge (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .d_i      (step_i),
        .flanco_o (step_edge)
    );

    assign start_go      = (state_q == ST_IDLE) && start_i;
    assign last_vec      = (op_q == OP_LAST) && (&a_q) && (&b_q);
    assign dwell_expired = (dwell_q == DWELL_LAST);

    // Checksum candidate for the result presented this cycle.
    always_comb begin
        chk_wide = checksum_next(CHK_MAX_W'(chk_q), CHK_MAX_W'(resultado_i), N);
        chk_next = chk_wide[N-1:0];
    end

    // Next-state decode; HOLD re-checks the advance mode every cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start_i) state_d = ST_SETUP;
            ST_SETUP:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (step_mode_i) begin
                    if (step_edge) state_d = ST_ADVANCE;
                end else if (dwell_expired) begin
                    state_d = ST_ADVANCE;
                end
            end
            ST_ADVANCE: state_d = last_vec ? ST_DONE : ST_SETUP;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Vector counters and latched per-sweep ALU configuration; the counters
    // drive the address/op buses directly so they stay put until ADVANCE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            inv_q <= 1'b0;
        end else if (start_go) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= cin_cfg_i;
            inv_q <= invert_cfg_i;
        end else if (state_q == ST_ADVANCE && !last_vec) begin
            b_q <= b_q + 1'b1;
            if (&b_q) begin
                a_q <= a_q + 1'b1;
                if (&a_q) begin
                    op_q <= op_q + 3'd1;
                end
            end
        end
    end

    // Result/carry capture and checksum accumulation; all held after DONE.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            chk_q   <= '0;
        end else if (start_go) begin
            chk_q <= '0;
        end else if (state_q == ST_CAPTURE) begin
            res_q   <= resultado_i;
            carry_q <= c_i;
            chk_q   <= chk_next;
        end
    end

    // Dwell timer: counts only in auto-mode HOLD, cleared everywhere else.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dwell_q <= '0;
        end else if (state_q == ST_HOLD) begin
            if (!step_mode_i) begin
                dwell_q <= dwell_expired ? '0 : dwell_q + 1'b1;
            end
        end else begin
            dwell_q <= '0;
        end
    end

    assign addra_o       = a_q;
    assign addrb_o       = b_q;
    assign operacion_o   = op_q;
    assign c_o           = cin_q;
    assign invert_o      = inv_q;
    assign resultado_q_o = res_q;
    assign carry_q_o     = carry_q;
    assign checksum_o    = chk_q;
    assign valid_o       = (state_q == ST_CAPTURE);
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer (N=32, ADDR_W=3, NUM_OPS=6, DWELL=2).
// The ALU is modelled either as {op,a,b} zero-extended or as constant 1.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        step_mode;
    logic        step;
    logic        cin_cfg;
    logic        invert_cfg;
    logic [31:0] resultado;
    logic        c_alu;
    logic [2:0]  addra;
    logic [2:0]  addrb;
    logic [2:0]  operacion;
    logic        c_out;
    logic        invert_out;
    logic [31:0] res_q;
    logic        carry_q;
    logic [31:0] checksum;
    logic        valid;
    logic        busy;
    logic        done;
    logic        model_const;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(
        .N       (32),
        .ADDR_W  (3),
        .NUM_OPS (6),
        .DWELL   (2)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .step_mode_i   (step_mode),
        .step_i        (step),
        .cin_cfg_i     (cin_cfg),
        .invert_cfg_i  (invert_cfg),
        .resultado_i   (resultado),
        .c_i           (c_alu),
        .addra_o       (addra),
        .addrb_o       (addrb),
        .operacion_o   (operacion),
        .c_o           (c_out),
        .invert_o      (invert_out),
        .resultado_q_o (res_q),
        .carry_q_o     (carry_q),
        .checksum_o    (checksum),
        .valid_o       (valid),
        .busy_o        (busy),
        .done_o        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment ALU model: fed from the DUT's buses, never used as an expectation.
    always_comb begin
        resultado = model_const ? 32'd1 : {23'd0, operacion, addra, addrb};
        c_alu     = addrb[0];
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [78:0] outs;
        rst_n = 1'b0; start = 1'b1;
        tick(); tick();
        outs = {addra, addrb, operacion, c_out, invert_out, res_q, carry_q, checksum, valid, busy, done};
        checks++;
        if (outs !== '0) begin errors++; $display("[TB] FAIL reset_outputs got=%h exp=0", outs); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        rst_n = 1'b1; start = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({busy, valid, done} !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_stays_idle got=%b exp=000", {busy, valid, done});
        end
    endtask

    task automatic test_auto_sweep();
        int nvalid = 0, ndone = 0, done_cyc = -1, first_valid = -1, last_valid = 0;
        int bad_space = 0, bad_val = 0;
        logic prev_valid = 1'b0;
        model_const = 1'b0; step_mode = 1'b0; cin_cfg = 1'b1; invert_cfg = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if ({busy, c_out} !== 2'b11) begin errors++; $display("[TB] FAIL auto_start got=%b exp=11", {busy, c_out}); end
        cin_cfg = 1'b0;
        for (int m = 1; m <= 1925; m++) begin
            if (prev_valid) begin
                if (res_q !== 32'(nvalid - 1)) bad_val++;
                if (nvalid == 3) begin
                    checks++;
                    if (res_q !== 32'h002) begin errors++; $display("[TB] FAIL capture3 got=%h exp=002", res_q); end
                end
                if (nvalid == 4) begin
                    checks++;
                    if (carry_q !== 1'b1) begin errors++; $display("[TB] FAIL carry4 got=%b exp=1", carry_q); end
                end
                if (nvalid == 9) begin
                    checks++;
                    if (res_q !== 32'h008) begin errors++; $display("[TB] FAIL capture9 got=%h exp=008", res_q); end
                end
                if (nvalid == 65) begin
                    checks++;
                    if (res_q !== 32'h040) begin errors++; $display("[TB] FAIL capture65 got=%h exp=040", res_q); end
                end
            end
            if (valid) begin
                if (nvalid == 0) first_valid = m;
                else if (m - last_valid != 5) bad_space++;
                last_valid = m;
                nvalid++;
            end
            if (done) begin ndone++; done_cyc = m; end
            if (m == 1922) begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("[TB] FAIL auto_busy_after_done got=%b exp=0", busy); end
            end
            prev_valid = valid;
            tick();
        end
        checks++;
        if (first_valid != 2) begin errors++; $display("[TB] FAIL first_valid got=%0d exp=2", first_valid); end
        checks++;
        if (nvalid != 384) begin errors++; $display("[TB] FAIL valid_count got=%0d exp=384", nvalid); end
        checks++;
        if (bad_space != 0) begin errors++; $display("[TB] FAIL valid_spacing got=%0d bad exp=0", bad_space); end
        checks++;
        if (bad_val != 0) begin errors++; $display("[TB] FAIL sweep_order got=%0d bad exp=0", bad_val); end
        checks++;
        if (ndone != 1 || done_cyc != 1921) begin
            errors++; $display("[TB] FAIL done_timing got=%0d pulses at %0d exp=1 at 1921", ndone, done_cyc);
        end
        checks++;
        if (c_out !== 1'b1) begin errors++; $display("[TB] FAIL cin_latched got=%b exp=1", c_out); end
    endtask

    task automatic test_checksum();
        int n = 0, ndone = 0;
        logic prev_valid = 1'b0;
        model_const = 1'b1; step_mode = 1'b0; cin_cfg = 1'b0; invert_cfg = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int m = 1; m <= 1925; m++) begin
            if (prev_valid && n == 32) begin
                checks++;
                if (checksum !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL checksum32 got=%h exp=ffffffff", checksum); end
            end
            if (prev_valid && n == 40) begin
                checks++;
                if (checksum !== 32'hFFFF_FF00) begin errors++; $display("[TB] FAIL checksum40 got=%h exp=ffffff00", checksum); end
            end
            if (valid) n++;
            if (done) begin
                ndone++;
                checks++;
                if ({checksum, invert_out} !== {32'h0, 1'b1}) begin
                    errors++; $display("[TB] FAIL checksum_done got=%h inv=%b exp=0 inv=1", checksum, invert_out);
                end
            end
            prev_valid = valid;
            tick();
        end
        checks++;
        if (ndone != 1) begin errors++; $display("[TB] FAIL checksum_done_seen got=%0d exp=1", ndone); end
        checks++;
        if ({busy, res_q, checksum} !== {1'b0, 32'd1, 32'd0}) begin
            errors++; $display("[TB] FAIL held_after_done got=%b %h %h exp=0 1 0", busy, res_q, checksum);
        end
    endtask

    task automatic test_step_mode();
        int cnt = 0;
        model_const = 1'b0; step_mode = 1'b1; step = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if ({busy, res_q} !== {1'b1, 32'd0}) begin errors++; $display("[TB] FAIL step_first got=%b %h exp=1 0", busy, res_q); end
        step = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (valid) cnt++;
        end
        checks++;
        if (cnt != 1 || res_q !== 32'd1) begin
            errors++; $display("[TB] FAIL step_held got=%0d vectors res=%h exp=1 res=1", cnt, res_q);
        end
        step = 1'b0; tick();
        for (int p = 0; p < 3; p++) begin
            step = 1'b1; tick(); step = 1'b0;
            for (int i = 0; i < 4; i++) tick();
        end
        checks++;
        if (res_q !== 32'd4) begin errors++; $display("[TB] FAIL step_three_pulses got=%h exp=4", res_q); end
        checks++;
        if ({operacion, addra, addrb} !== 9'd4) begin
            errors++; $display("[TB] FAIL step_addr got=%h exp=4", {operacion, addra, addrb});
        end
    endtask

    task automatic test_mid_sweep();
        int cnt = 0;
        logic [78:0] outs;
        step_mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (valid) cnt++;
        end
        checks++;
        if (cnt != 1 || res_q !== 32'd5) begin
            errors++; $display("[TB] FAIL mode_switch got=%0d vectors res=%h exp=1 res=5", cnt, res_q);
        end
        start = 1'b1; tick(); start = 1'b0; tick();
        checks++;
        if ({busy, res_q, operacion, addra, addrb} !== {1'b1, 32'd6, 9'd6}) begin
            errors++; $display("[TB] FAIL start_ignored got=%b %h %h exp=1 6 6", busy, res_q, {operacion, addra, addrb});
        end
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        outs = {addra, addrb, operacion, c_out, invert_out, res_q, carry_q, checksum, valid, busy, done};
        checks++;
        if (outs !== '0) begin errors++; $display("[TB] FAIL midsweep_reset got=%h exp=0", outs); end
        tick(); tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_after got=%b exp=0", busy); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0;
        cin_cfg = 1'b0; invert_cfg = 1'b0; model_const = 1'b0;
        @(negedge clk);
        test_reset();
        test_auto_sweep();
        test_checksum();
        test_step_mode();
        test_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
